// File: rtl/axis_batch_pkg.sv
// ============================================================================
// Module      : axis_batch_pkg
// Description : Shared state encoding and counter widths for the batch
//               controller and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_batch_pkg;

    localparam int FRAME_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4
    } batch_state_e;

endpackage

`default_nettype wire

// File: rtl/axis_skid2.sv
// ============================================================================
// Module      : axis_skid2
// Description : Two-entry first-word-fall-through buffer with occupancy
//               output; entry 0 is always the head presented downstream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_skid2 #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [1:0]       o_occ
);

    logic [WIDTH-1:0] r_d0;
    logic [WIDTH-1:0] r_d1;
    logic [1:0]       r_occ;
    logic             w_pop;

    assign w_pop   = i_pop & (r_occ != 2'd0);
    assign o_data  = r_d0;
    assign o_valid = (r_occ != 2'd0);
    assign o_occ   = r_occ;

    // The upstream read-credit check guarantees a push never lands on a full buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d0  <= '0;
            r_d1  <= '0;
            r_occ <= 2'd0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_d0  <= i_data;
                        r_occ <= 2'd1;
                    end else if (r_occ == 2'd1) begin
                        r_d1  <= i_data;
                        r_occ <= 2'd2;
                    end
                end
                2'b01: begin
                    r_d0  <= r_d1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_d0 <= i_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/axis_batch_ctrl.sv
// ============================================================================
// Module      : axis_batch_ctrl
// Description : Loads a fixed-size AXI-Stream frame into a compute core,
//               starts it, then streams the core results back out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_batch_ctrl
    import axis_batch_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int IN_WORDS  = 20,
    parameter int OUT_WORDS = 11,
    localparam int IN_AW    = $clog2(IN_WORDS),
    localparam int OUT_AW   = $clog2(OUT_WORDS)
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [DATA_W-1:0]      s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   core_wr_en,
    output logic [IN_AW-1:0]       core_wr_addr,
    output logic [DATA_W-1:0]      core_wr_data,
    output logic                   core_start,
    input  logic                   core_finish,
    output logic                   core_rd_en,
    output logic [OUT_AW-1:0]      core_rd_addr,
    input  logic [DATA_W-1:0]      core_rd_data,
    output logic                   err_frame,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   idle
);

    localparam logic [IN_AW-1:0]  c_IN_LAST  = IN_AW'(IN_WORDS - 1);
    localparam logic [OUT_AW-1:0] c_OUT_LAST = OUT_AW'(OUT_WORDS - 1);

    batch_state_e           r_state;
    batch_state_e           w_state_nxt;
    logic [IN_AW-1:0]       r_wr_cnt;
    logic [OUT_AW-1:0]      r_rd_addr;
    logic                   r_rd_all;
    logic                   r_rd_pend;
    logic                   r_rd_last;
    logic                   r_err;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    logic                   w_in_hs;
    logic                   w_pop;
    logic                   w_err_set;
    logic                   w_rd_issue;
    logic                   w_frame_done;
    logic [2:0]             w_credit;
    logic [1:0]             w_occ;
    logic [DATA_W:0]        w_skid_data;
    logic                   w_skid_valid;

    assign w_in_hs = s_axis_tvalid & s_axis_tready;
    assign w_pop   = m_axis_tvalid & m_axis_tready;

    // Words already buffered plus words still coming back from the core.
    assign w_credit   = {1'b0, w_occ} + {2'b00, r_rd_pend} - {2'b00, w_pop};
    assign w_rd_issue = (r_state == ST_DRAIN) && !r_rd_all && (w_credit < 3'd2);

    assign w_frame_done = (r_state == ST_DRAIN) && w_pop && m_axis_tlast;

    assign core_wr_addr = r_wr_cnt;
    assign core_rd_addr = r_rd_addr;
    assign err_frame    = r_err;
    assign frame_cnt    = r_frame_cnt;
    assign idle         = (r_state == ST_LOAD) && (r_wr_cnt == '0);

    always_comb begin
        w_state_nxt   = r_state;
        s_axis_tready = 1'b0;
        core_wr_en    = 1'b0;
        core_wr_data  = '0;
        core_start    = 1'b0;
        core_rd_en    = 1'b0;
        w_err_set     = 1'b0;
        case (r_state)
            ST_LOAD: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    core_wr_en   = 1'b1;
                    core_wr_data = s_axis_tdata;
                    if (r_wr_cnt == c_IN_LAST) begin
                        if (s_axis_tlast) begin
                            w_state_nxt = ST_START;
                        end else begin
                            w_err_set   = 1'b1;
                            w_state_nxt = ST_FLUSH;
                        end
                    end else if (s_axis_tlast) begin
                        w_err_set = 1'b1;
                    end
                end
            end
            ST_START: begin
                core_start  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_finish) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                core_rd_en = w_rd_issue;
                if (w_frame_done) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= ST_LOAD;
            r_wr_cnt    <= '0;
            r_rd_addr   <= '0;
            r_rd_all    <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_last   <= 1'b0;
            r_err       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_pend <= w_rd_issue;
            r_rd_last <= w_rd_issue && (r_rd_addr == c_OUT_LAST);
            if ((r_state == ST_LOAD) && w_in_hs) begin
                if (s_axis_tlast || (r_wr_cnt == c_IN_LAST)) begin
                    r_wr_cnt <= '0;
                end else begin
                    r_wr_cnt <= r_wr_cnt + IN_AW'(1);
                end
            end
            if (w_rd_issue) begin
                if (r_rd_addr == c_OUT_LAST) begin
                    r_rd_all  <= 1'b1;
                    r_rd_addr <= '0;
                end else begin
                    r_rd_addr <= r_rd_addr + OUT_AW'(1);
                end
            end
            if (w_frame_done) begin
                r_rd_all    <= 1'b0;
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Core read data arrives one cycle after the strobe; tag the last word on the way in.
    axis_skid2 #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .clk     (aclk),
        .rst     (areset),
        .i_push  (r_rd_pend),
        .i_data  ({r_rd_last, core_rd_data}),
        .i_pop   (m_axis_tready),
        .o_data  (w_skid_data),
        .o_valid (w_skid_valid),
        .o_occ   (w_occ)
    );

    assign m_axis_tvalid = w_skid_valid;
    assign m_axis_tdata  = w_skid_data[DATA_W-1:0];
    assign m_axis_tlast  = w_skid_data[DATA_W] & w_skid_valid;

endmodule

`default_nettype wire

// File: tb/tb_axis_batch_ctrl.sv
// ============================================================================
// Module      : tb_axis_batch_ctrl
// Description : Randomized bench for axis_batch_ctrl with a frame-level
//               reference model and a behavioural compute core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_batch_ctrl;

    localparam int DW  = 64;
    localparam int IW  = 20;
    localparam int OW  = 11;
    localparam int IAW = $clog2(IW);
    localparam int OAW = $clog2(OW);

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic           aclk;
    logic           areset;
    logic [DW-1:0]  s_axis_tdata;
    logic           s_axis_tvalid;
    logic           s_axis_tlast;
    logic           s_axis_tready;
    logic [DW-1:0]  m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready;
    logic           core_wr_en;
    logic [IAW-1:0] core_wr_addr;
    logic [DW-1:0]  core_wr_data;
    logic           core_start;
    logic           core_finish;
    logic           core_rd_en;
    logic [OAW-1:0] core_rd_addr;
    logic [DW-1:0]  core_rd_data;
    logic           err_frame;
    logic [15:0]    frame_cnt;
    logic           idle;

    axis_batch_ctrl #(
        .DATA_W    (DW),
        .IN_WORDS  (IW),
        .OUT_WORDS (OW)
    ) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .core_wr_en    (core_wr_en),
        .core_wr_addr  (core_wr_addr),
        .core_wr_data  (core_wr_data),
        .core_start    (core_start),
        .core_finish   (core_finish),
        .core_rd_en    (core_rd_en),
        .core_rd_addr  (core_rd_addr),
        .core_rd_data  (core_rd_data),
        .err_frame     (err_frame),
        .frame_cnt     (frame_cnt),
        .idle          (idle)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // The bench's compute core: each result word mixes two loaded words.
    function automatic logic [63:0] core_fn(input logic [63:0] a, input logic [63:0] b);
        return (a + {b[31:0], b[63:32]}) ^ 64'h5A5A_0F0F_A5A5_F0F0;
    endfunction

    // Frame-level reference model state.
    beat_t exp_q[$];
    int    exp_frames  = 0;
    int    exp_starts  = 0;
    logic  exp_err     = 1'b0;
    int    done_frames = 0;

    int    rdy_mode = 0;
    int    lat_cfg  = 5;
    bit    spur_fin = 1'b0;
    int    n_starts = 0;
    int    n_out    = 0;
    int    n_last   = 0;
    int    outs_in_frame = 0;
    int    cyc = 0;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        forever begin
            @(posedge aclk);
            cyc++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #2;
            case (rdy_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Behavioural core: input RAM, snapshot at start, 1-cycle read latency.
    logic [DW-1:0] in_mem  [IW];
    logic [DW-1:0] out_mem [OW];
    initial begin
        int fin_cnt;
        bit rv;
        int ra;
        fin_cnt = 0;
        core_finish  = 1'b0;
        core_rd_data = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                fin_cnt = 0;
            end else begin
                if (core_start) begin
                    n_starts++;
                    for (int k = 0; k < OW; k++) out_mem[k] = core_fn(in_mem[k], in_mem[IW-1-k]);
                    fin_cnt = lat_cfg;
                end
                if (core_wr_en && (int'(core_wr_addr) < IW)) in_mem[core_wr_addr] = core_wr_data;
            end
            rv = core_rd_en && !areset;
            ra = int'(core_rd_addr);
            @(posedge aclk);
            #1;
            core_rd_data = (rv && ra < OW) ? out_mem[ra] : {$urandom, $urandom};
            if (fin_cnt > 0) begin
                fin_cnt--;
                core_finish = (fin_cnt == 0);
            end else begin
                core_finish = spur_fin;
            end
            spur_fin = 1'b0;
        end
    end

    // Output monitor against the expected-beat queue.
    initial begin
        int    first_rd;
        int    first_v;
        bit    prev_stall;
        bit    chk_next;
        logic [DW-1:0] prev_data;
        logic  prev_last;
        beat_t b;
        first_rd = -1; first_v = -1; prev_stall = 0; chk_next = 0;
        prev_data = '0; prev_last = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                first_rd = -1; first_v = -1; prev_stall = 0; chk_next = 0; outs_in_frame = 0;
                continue;
            end
            if (chk_next) begin
                check_eq("frame_cnt_step", frame_cnt, 64'(done_frames & 16'hFFFF));
                check_eq("back_to_load_ready", s_axis_tready, 1);
                chk_next = 0;
            end
            if (prev_stall) begin
                check_eq("stall_valid_held", m_axis_tvalid, 1);
                check_eq("stall_data_held", m_axis_tdata, prev_data);
                check_eq("stall_last_held", m_axis_tlast, prev_last);
            end
            if (core_rd_en && first_rd < 0) first_rd = cyc;
            if (m_axis_tvalid && first_v < 0) first_v = cyc;
            if (m_axis_tvalid && m_axis_tready) begin
                n_out++;
                if (m_axis_tlast) n_last++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_beat", m_axis_tvalid, 0);
                end else begin
                    b = exp_q.pop_front();
                    check_eq("out_data", m_axis_tdata, b.data);
                    check_eq("out_last", m_axis_tlast, b.last);
                    outs_in_frame++;
                    if (b.last) begin
                        done_frames++;
                        chk_next = 1;
                        if (rdy_mode == 0) begin
                            check_eq("rd_to_valid_latency", 64'(first_v - first_rd), 2);
                            check_eq("drain_burst_cycles", 64'(cyc - first_v), OW - 1);
                        end
                        first_rd = -1; first_v = -1; outs_in_frame = 0;
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic send_frame(input int n_words, input bit incr, input bit nogap);
        logic [DW-1:0] w[$];
        bit hs;
        for (int i = 0; i < n_words; i++) w.push_back(incr ? 64'(i + 1) : {$urandom, $urandom});
        @(posedge aclk);
        #2;
        for (int i = 0; i < n_words; i++) begin
            if (!nogap && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                @(posedge aclk);
                #2;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = w[i];
            s_axis_tlast  = (i == n_words - 1);
            hs = 0;
            for (int t = 0; t < 1000 && !hs; t++) begin
                #1;
                if (s_axis_tready) begin
                    hs = 1;
                    check_eq("wr_en", core_wr_en, (i < IW));
                    if (i < IW) begin
                        check_eq("wr_addr", core_wr_addr, 64'(i));
                        check_eq("wr_data", core_wr_data, w[i]);
                    end
                end
                @(posedge aclk);
                #2;
            end
            if (!hs) begin
                check_eq("s_ready_timeout", s_axis_tready, 1);
                break;
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        if (n_words == IW) begin
            for (int k = 0; k < OW; k++)
                exp_q.push_back('{last: (k == OW - 1), data: core_fn(w[k], w[IW-1-k])});
            exp_frames++;
            exp_starts++;
        end else begin
            exp_err = 1'b1;
        end
    endtask

    task automatic wait_drained();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge aclk);
            #1;
            t++;
        end
        if (exp_q.size() != 0) check_eq("drain_timeout", 64'(exp_q.size()), 0);
        repeat (2) @(negedge aclk);
        #1;
        check_eq("frame_cnt", frame_cnt, 64'(exp_frames & 16'hFFFF));
        check_eq("start_count", 64'(n_starts), 64'(exp_starts));
        check_eq("err_frame", err_frame, exp_err);
        check_eq("idle_after_frame", idle, 1);
        check_eq("no_valid_after_frame", m_axis_tvalid, 0);
    endtask

    task automatic settle_bad();
        repeat (3) @(negedge aclk);
        #1;
        check_eq("err_frame_bad", err_frame, exp_err);
        check_eq("no_start_bad", 64'(n_starts), 64'(exp_starts));
        check_eq("idle_bad", idle, 1);
        check_eq("ready_bad", s_axis_tready, 1);
    endtask

    initial begin
        int t;
        int out0;
        int last0;
        int kind;
        areset        = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_eq("rst_s_ready", s_axis_tready, 1);
        check_eq("rst_m_valid", m_axis_tvalid, 0);
        check_eq("rst_m_last", m_axis_tlast, 0);
        check_eq("rst_m_data", m_axis_tdata, 0);
        check_eq("rst_wr_en", core_wr_en, 0);
        check_eq("rst_wr_addr", core_wr_addr, 0);
        check_eq("rst_wr_data", core_wr_data, 0);
        check_eq("rst_start", core_start, 0);
        check_eq("rst_rd_en", core_rd_en, 0);
        check_eq("rst_rd_addr", core_rd_addr, 0);
        check_eq("rst_err", err_frame, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        check_eq("rst_idle", idle, 1);
        @(posedge aclk);
        #2;
        areset = 1'b0;

        // A finish pulse outside WAIT must be ignored.
        spur_fin = 1'b1;
        repeat (4) @(negedge aclk);
        #1;
        check_eq("spurious_finish_idle", idle, 1);
        check_eq("spurious_finish_no_rd", core_rd_en, 0);
        check_eq("spurious_finish_no_valid", m_axis_tvalid, 0);

        // Nominal frame 0x1..0x14.
        rdy_mode = 0; lat_cfg = 5;
        send_frame(IW, 1'b1, 1'b1);
        wait_drained();

        // Alternating backpressure.
        rdy_mode = 1;
        send_frame(IW, 1'b0, 1'b0);
        wait_drained();

        // Short frame, then a good one.
        rdy_mode = 0;
        send_frame(7, 1'b0, 1'b0);
        settle_bad();
        send_frame(IW, 1'b0, 1'b0);
        wait_drained();

        // Long frame.
        send_frame(25, 1'b0, 1'b0);
        settle_bad();

        // Reset in the middle of draining.
        rdy_mode = 0; lat_cfg = 3;
        send_frame(IW, 1'b0, 1'b1);
        t = 0;
        while (outs_in_frame < 4 && t < 500) begin
            @(negedge aclk);
            #1;
            t++;
        end
        check_eq("reached_4_outputs", 64'(outs_in_frame >= 4), 1);
        @(posedge aclk);
        #2;
        areset = 1'b1;
        @(posedge aclk);
        #2;
        areset = 1'b0;
        exp_q.delete();
        exp_frames = 0; exp_starts = 0; exp_err = 1'b0; done_frames = 0; n_starts = 0;
        @(negedge aclk);
        #1;
        check_eq("abort_valid", m_axis_tvalid, 0);
        check_eq("abort_idle", idle, 1);
        check_eq("abort_frame_cnt", frame_cnt, 0);
        check_eq("abort_err", err_frame, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge aclk);
            #1;
            check_eq("abort_no_valid", m_axis_tvalid, 0);
        end
        send_frame(IW, 1'b0, 1'b0);
        wait_drained();

        // Three frames back to back.
        rdy_mode = 0; lat_cfg = 5;
        out0 = n_out; last0 = n_last;
        for (int f = 0; f < 3; f++) send_frame(IW, 1'b0, 1'b1);
        wait_drained();
        check_eq("b2b_outputs", 64'(n_out - out0), 3 * OW);
        check_eq("b2b_tlast", 64'(n_last - last0), 3);

        // Randomized mix of good, short and long frames.
        for (int f = 0; f < 10; f++) begin
            rdy_mode = $urandom_range(0, 2);
            lat_cfg  = $urandom_range(1, 8);
            kind     = $urandom_range(0, 9);
            if (kind < 7) begin
                send_frame(IW, 1'b0, 1'b0);
                wait_drained();
            end else if (kind == 7) begin
                send_frame($urandom_range(1, IW - 1), 1'b0, 1'b0);
                settle_bad();
            end else begin
                send_frame($urandom_range(IW + 1, IW + 8), 1'b0, 1'b0);
                settle_bad();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
